// File: rtl/pspin_stdout_fifo.sv
// Stdout collector: merges per-cluster 32-bit words through a round-robin arbiter
// into a first-word-fall-through FIFO, with a vendor-style reset-busy start-up window.
module pspin_stdout_fifo #(
  parameter int NUM_CLUSTERS    = 2,
  parameter int DEPTH           = 512,
  parameter int RST_BUSY_CYCLES = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CLUSTERS*32-1:0] s_wr_data,
  input  logic [NUM_CLUSTERS-1:0]    s_wr_valid,
  output logic [NUM_CLUSTERS-1:0]    s_wr_ready,
  input  logic                       stdout_rd_en,
  output logic                       stdout_rd_rst_busy,
  output logic [31:0]                stdout_dout,
  output logic                       stdout_empty,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
  localparam int BW = $clog2(RST_BUSY_CYCLES + 1);

  typedef enum logic {ST_BUSY, ST_RUN} state_t;

  state_t          r_state, w_state_next;
  logic [BW-1:0]   r_busy_cnt;
  logic [31:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [AW:0]     r_count;
  logic [CW-1:0]   r_rr_ptr, w_winner;
  logic            w_found, w_run, w_full, w_grant, w_push, w_pop;

  assign w_run = (r_state == ST_RUN);

  // NOTE: always_comb assigns a default to every output first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_BUSY && r_busy_cnt <= BW'(1))
      w_state_next = ST_RUN;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_BUSY;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_busy_cnt <= BW'(RST_BUSY_CYCLES);
    else if (r_state == ST_BUSY && r_busy_cnt != '0)
      r_busy_cnt <= r_busy_cnt - BW'(1);
  end

  // Round-robin search starting at r_rr_ptr, wrapping at NUM_CLUSTERS.
  always_comb begin : arb
    int unsigned idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int off = 0; off < NUM_CLUSTERS; off++) begin
      idx = int'(r_rr_ptr) + off;
      if (idx >= NUM_CLUSTERS) idx = idx - NUM_CLUSTERS;
      if (!w_found && s_wr_valid[CW'(idx)]) begin
        w_found  = 1'b1;
        w_winner = CW'(idx);
      end
    end
  end

  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_grant    = w_run && !w_full && w_found;
  assign s_wr_ready = w_grant ? (NUM_CLUSTERS'(1) << w_winner) : '0;
  assign w_push     = w_grant;
  assign w_pop      = stdout_rd_en && w_run && !stdout_empty;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_rr_ptr <= '0;
    else if (w_push)
      r_rr_ptr <= (int'(w_winner) == NUM_CLUSTERS - 1) ? '0 : w_winner + CW'(1);
  end

  // NOTE: the storage array has no reset; emptiness is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_wr_data[32*w_winner +: 32];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign stdout_empty       = (r_count == '0);
  assign fifo_level         = r_count;
  assign stdout_rd_rst_busy = !w_run;
  assign stdout_dout        = stdout_empty ? 32'h0 : r_mem[r_rd_ptr];

endmodule

// File: tb/tb_pspin_stdout_fifo.sv
// Directed bench for pspin_stdout_fifo: a cycle model predicts grants, flags and
// the head word; a scoreboard queue holds accepted words until they are popped.
module tb_pspin_stdout_fifo;

  localparam int NC    = 2;
  localparam int DEPTH = 4;
  localparam int RB    = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NC*32-1:0] s_wr_data = '0;
  logic [NC-1:0]    s_wr_valid = '0;
  logic [NC-1:0]    s_wr_ready;
  logic             stdout_rd_en = 1'b0;
  logic             stdout_rd_rst_busy;
  logic [31:0]      stdout_dout;
  logic             stdout_empty;
  logic [LW-1:0]    fifo_level;

  always #5 clk = ~clk;

  pspin_stdout_fifo #(
    .NUM_CLUSTERS(NC), .DEPTH(DEPTH), .RST_BUSY_CYCLES(RB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_wr_data(s_wr_data), .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready),
    .stdout_rd_en(stdout_rd_en), .stdout_rd_rst_busy(stdout_rd_rst_busy),
    .stdout_dout(stdout_dout), .stdout_empty(stdout_empty), .fifo_level(fifo_level)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] src0[$];
  logic [31:0] src1[$];
  logic [31:0] sb[$];
  int m_level, m_rr, m_edges;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check model, advance the model past the rising edge.
  task automatic step(input logic rd);
    int          win;
    logic [NC-1:0] gnt;
    bit          run, popd;
    s_wr_valid   = {src1.size() > 0, src0.size() > 0};
    s_wr_data    = {(src1.size() > 0) ? src1[0] : 32'h0, (src0.size() > 0) ? src0[0] : 32'h0};
    stdout_rd_en = rd;
    #1;
    run = (m_edges >= RB);
    win = -1;
    gnt = '0;
    if (run && m_level < DEPTH)
      for (int off = 0; off < NC; off++) begin
        int c = (m_rr + off) % NC;
        if (win < 0 && ((s_wr_valid >> c) & 1) != 0) win = c;
      end
    if (win >= 0) gnt = NC'(1) << win;
    check("ready", 32'(s_wr_ready), 32'(gnt));
    check("busy", 32'(stdout_rd_rst_busy), 32'(!run));
    check("level", 32'(fifo_level), 32'(m_level));
    check("empty", 32'(stdout_empty), 32'(m_level == 0));
    check("dout", stdout_dout, (m_level > 0) ? sb[0] : 32'h0);
    @(posedge clk);
    popd = rd && run && (m_level > 0);
    if (popd) void'(sb.pop_front());
    if (win == 0) sb.push_back(src0.pop_front());
    else if (win == 1) sb.push_back(src1.pop_front());
    if (win >= 0) m_rr = (win + 1) % NC;
    m_level = m_level + ((win >= 0) ? 1 : 0) - (popd ? 1 : 0);
    m_edges++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    stdout_rd_en = 1'b0;
    s_wr_valid   = '0;
    s_wr_data    = '0;
    src0.delete();
    src1.delete();
    @(posedge clk);
    sb.delete();
    m_level = 0;
    m_rr    = 0;
    m_edges = 0;
    @(negedge clk);
    check("rst_busy", 32'(stdout_rd_rst_busy), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_empty", 32'(stdout_empty), 32'd1);
    check("rst_ready", 32'(s_wr_ready), 32'd0);
    check("rst_dout", stdout_dout, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] ord [4];

    @(negedge clk);

    // Reset release: both clusters request during the busy window.
    do_reset();
    src0.push_back(32'h100);
    src1.push_back(32'h200);
    repeat (RB) step(1'b1);
    check("t1_busy_low", 32'(stdout_rd_rst_busy), 32'd0);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    step(1'b1);
    step(1'b0);

    // Single-cluster ordering.
    do_reset();
    src0.push_back(32'hA0);
    src0.push_back(32'hA1);
    src0.push_back(32'hA2);
    repeat (RB) step(1'b0);
    step(1'b0);
    check("t2_first_dout", stdout_dout, 32'hA0);
    step(1'b0);
    step(1'b0);
    check("t2_level3", 32'(fifo_level), 32'd3);
    repeat (3) step(1'b1);
    step(1'b0);
    check("t2_empty", 32'(stdout_empty), 32'd1);

    // Round-robin fairness from rr_ptr = 0.
    do_reset();
    src0.push_back(32'h10);
    src0.push_back(32'h11);
    src1.push_back(32'h20);
    src1.push_back(32'h21);
    repeat (RB) step(1'b0);
    repeat (4) step(1'b0);
    ord[0] = 32'h10; ord[1] = 32'h20; ord[2] = 32'h11; ord[3] = 32'h21;
    for (int i = 0; i < 4; i++) begin
      check("t3_order", stdout_dout, ord[i]);
      step(1'b1);
    end

    // Full and backpressure.
    for (int i = 0; i < 5; i++) src0.push_back(32'h40 + 32'(i));
    repeat (4) step(1'b0);
    check("t4_level_full", 32'(fifo_level), 32'd4);
    step(1'b0);
    check("t4_ready_full", 32'(s_wr_ready), 32'd0);
    step(1'b1);
    check("t4_pop_no_push", 32'(fifo_level), 32'd3);
    step(1'b0);
    check("t4_refill", 32'(fifo_level), 32'd4);
    repeat (4) step(1'b1);

    // Simultaneous push/pop across pointer wrap, then pops on empty.
    for (int i = 0; i < 3*DEPTH + 1; i++) src0.push_back(32'h500 + 32'(i));
    step(1'b0);
    for (int i = 0; i < 3*DEPTH; i++) begin
      step(1'b1);
      check("t5_level_const", 32'(fifo_level), 32'd1);
    end
    step(1'b1);
    step(1'b1);
    step(1'b1);
    src0.push_back(32'h77);
    step(1'b0);
    check("t5_after_empty_pop", stdout_dout, 32'h77);
    step(1'b1);

    // Reset mid-stream with a full FIFO.
    for (int i = 0; i < DEPTH; i++) src0.push_back(32'h900 + 32'(i));
    repeat (DEPTH) step(1'b0);
    check("t6_level_before", 32'(fifo_level), 32'(DEPTH));
    do_reset();
    src0.push_back(32'h60);
    src0.push_back(32'h61);
    repeat (RB) step(1'b0);
    step(1'b0);
    step(1'b0);
    check("t6_first", stdout_dout, 32'h60);
    step(1'b1);
    check("t6_second", stdout_dout, 32'h61);
    step(1'b1);
    check("t6_empty", 32'(stdout_empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
